// File: rtl/muldiv_if.sv
// Handshake and data bundle between the Execute stage and the RV32M multiply/divide sequencer.
// The pipeline side drives the operation; the sequencer returns stall, busy, done and result.
interface muldiv_if #(
    parameter int XLEN = 32
) ();
    logic            start_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic            flush_i;
    logic            stall_o;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output start_i, funct3_i, rs1_i, rs2_i, flush_i,
        input  stall_o, busy_o, done_o, result_o
    );

    modport slave (
        input  start_i, funct3_i, rs1_i, rs2_i, flush_i,
        output stall_o, busy_o, done_o, result_o
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on magnitudes,
// one bit per cycle, with sign fixup and single-cycle handling of divide corner cases.
module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input logic     clk,
    input logic     rst_n,
    muldiv_if.slave bus
);
    localparam int CW = $clog2(XLEN);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    localparam logic [CW-1:0]   LAST_COUNT = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_INT    = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state;
    logic [CW-1:0]     count;
    logic [2:0]        op;
    logic [XLEN-1:0]   addend;     // multiplicand or divisor magnitude
    logic [2*XLEN-1:0] acc;        // product accumulator; low word doubles as dividend/quotient
    logic [XLEN:0]     remReg;
    logic              signQ;      // sign of product or quotient
    logic              signR;      // sign of remainder (dividend sign)
    logic [XLEN-1:0]   resultReg;

    // Accept-cycle decode
    logic            isDiv, signedA, signedB, aNeg, bNeg, divByZero, overflow, fastPath;
    logic [XLEN-1:0] absA, absB, fastResult;

    always_comb begin
        isDiv     = bus.funct3_i[2];
        signedA   = (bus.funct3_i == OP_MULH) || (bus.funct3_i == OP_MULHSU) ||
                    (bus.funct3_i == OP_DIV)  || (bus.funct3_i == OP_REM);
        signedB   = (bus.funct3_i == OP_MULH) || (bus.funct3_i == OP_DIV) ||
                    (bus.funct3_i == OP_REM);
        aNeg      = signedA && bus.rs1_i[XLEN-1];
        bNeg      = signedB && bus.rs2_i[XLEN-1];
        absA      = aNeg ? -bus.rs1_i : bus.rs1_i;
        absB      = bNeg ? -bus.rs2_i : bus.rs2_i;
        divByZero = isDiv && (bus.rs2_i == '0);
        overflow  = isDiv && !bus.funct3_i[0] && (bus.rs1_i == MIN_INT) && (bus.rs2_i == '1);
        fastPath  = divByZero || overflow;
        if (divByZero) begin
            fastResult = bus.funct3_i[1] ? bus.rs1_i : '1;
        end else begin
            fastResult = bus.funct3_i[1] ? '0 : MIN_INT;
        end
    end

    // One iteration step for both datapaths, plus the final result built from the last step
    logic [XLEN:0]     mulSum, trial, diff, remNext;
    logic [2*XLEN-1:0] mulNext, product;
    logic [XLEN-1:0]   quotNext, quotSigned, remSigned, finalResult;

    always_comb begin
        mulSum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, addend} : '0);
        mulNext    = {mulSum, acc[XLEN-1:1]};
        trial      = {remReg[XLEN-1:0], acc[XLEN-1]};
        diff       = trial - {1'b0, addend};
        quotNext   = {acc[XLEN-2:0], ~diff[XLEN]};
        remNext    = diff[XLEN] ? trial : diff;
        product    = signQ ? -mulNext : mulNext;
        quotSigned = signQ ? -quotNext : quotNext;
        remSigned  = signR ? -remNext[XLEN-1:0] : remNext[XLEN-1:0];
        if (op[2]) begin
            finalResult = op[1] ? remSigned : quotSigned;
        end else begin
            finalResult = (op == OP_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
        end
    end

    // NOTE: every register here, the datapath included, is reset so a mid-operation reset
    // leaves no stale magnitudes behind; non-blocking assignment keeps all updates on one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            op        <= '0;
            addend    <= '0;
            acc       <= '0;
            remReg    <= '0;
            signQ     <= 1'b0;
            signR     <= 1'b0;
            resultReg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_i && !bus.flush_i) begin
                        op     <= bus.funct3_i;
                        count  <= '0;
                        remReg <= '0;
                        signQ  <= aNeg ^ bNeg;
                        signR  <= aNeg;
                        if (isDiv) begin
                            addend <= absB;
                            acc    <= {{XLEN{1'b0}}, absA};
                        end else begin
                            addend <= absA;
                            acc    <= {{XLEN{1'b0}}, absB};
                        end
                        if (fastPath) begin
                            resultReg <= fastResult;
                            state     <= DONE;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (bus.flush_i) begin
                        state <= IDLE;
                    end else begin
                        count <= count + 1'b1;
                        if (op[2]) begin
                            acc    <= {acc[2*XLEN-1:XLEN], quotNext};
                            remReg <= remNext;
                        end else begin
                            acc <= mulNext;
                        end
                        if (count == LAST_COUNT) begin
                            resultReg <= finalResult;
                            state     <= DONE;
                        end
                    end
                end
                default: state <= IDLE;   // DONE always retires; start_i is still the same op
            endcase
        end
    end

    assign bus.busy_o   = (state == BUSY);
    assign bus.stall_o  = ((state == IDLE) && bus.start_i && !bus.flush_i) || (state == BUSY);
    assign bus.done_o   = (state == DONE) && !bus.flush_i;
    assign bus.result_o = resultReg;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: reference model feeds a scoreboard queue at issue time,
// results are popped at done and compared along with latency, stall length, flush and reset.
module tb_muldiv_sequencer;
    localparam int XLEN = 32;
    localparam logic [31:0] MIN_INT = 32'h8000_0000;

    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_if #(.XLEN(XLEN)) bus ();

    muldiv_sequencer #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] expQ[$];
    logic [31:0] lastResult = '0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] refResult(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        logic signed [63:0] sa64, sb64;
        logic signed [31:0] sa, sb;
        logic [63:0]        p;
        logic [31:0]        r;
        sa = a;
        sb = b;
        r  = '0;
        case (f)
            MUL:    begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
            MULH:   begin
                        sa64 = {{32{a[31]}}, a}; sb64 = {{32{b[31]}}, b};
                        p = sa64 * sb64; r = p[63:32];
                    end
            MULHSU: begin
                        sa64 = {{32{a[31]}}, a}; sb64 = {32'b0, b};
                        p = sa64 * sb64; r = p[63:32];
                    end
            MULHU:  begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
            DIV:    r = (b == 0) ? 32'hFFFF_FFFF :
                        (a == MIN_INT && b == 32'hFFFF_FFFF) ? MIN_INT : 32'(sa / sb);
            DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            REM:    r = (b == 0) ? a :
                        (a == MIN_INT && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(sa % sb);
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    // Issue one op in the cycle after the current one; returns at the negedge of the done cycle
    // with start_i still held, as the pipeline would.
    task automatic runOp(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] expRes, popped;
        int          expLat, cycles, stallCnt;
        bit          fast;
        @(negedge clk);
        expRes = refResult(f, a, b);
        fast   = f[2] && ((b == 0) || (!f[0] && a == MIN_INT && b == 32'hFFFF_FFFF));
        expLat = fast ? 1 : 33;
        bus.start_i  = 1'b1;
        bus.funct3_i = f;
        bus.rs1_i    = a;
        bus.rs2_i    = b;
        expQ.push_back(expRes);
        #1;
        check("accept_stall", 32'(bus.stall_o), 32'd1);
        check("accept_busy", 32'(bus.busy_o), 32'd0);
        check("accept_done", 32'(bus.done_o), 32'd0);
        stallCnt = 1;
        cycles   = 0;
        while (1) begin
            @(negedge clk);
            cycles++;
            if (bus.done_o === 1'b1 || cycles >= 100) break;
            if (bus.stall_o === 1'b1) stallCnt++;
            bus.rs1_i = $urandom;
            bus.rs2_i = $urandom;
        end
        check("done_seen", 32'(bus.done_o), 32'd1);
        check("latency", 32'(cycles), 32'(expLat));
        check("stall_cycles", 32'(stallCnt), 32'(expLat));
        check("stall_in_done", 32'(bus.stall_o), 32'd0);
        check("busy_in_done", 32'(bus.busy_o), 32'd0);
        check("scoreboard_depth", 32'(expQ.size()), 32'd1);
        popped = (expQ.size() > 0) ? expQ.pop_front() : 32'hDEAD_BEEF;
        check($sformatf("result f3=%0d a=%h b=%h", f, a, b), bus.result_o, popped);
        lastResult = popped;
    endtask

    task automatic endOp();
        bus.start_i = 1'b0;
        @(negedge clk);
        #1;
        check("idle_done", 32'(bus.done_o), 32'd0);
        check("idle_busy", 32'(bus.busy_o), 32'd0);
        check("idle_stall", 32'(bus.stall_o), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed hang expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int doneCount;
        bus.start_i  = 1'b0;
        bus.funct3_i = '0;
        bus.rs1_i    = '0;
        bus.rs2_i    = '0;
        bus.flush_i  = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        check("reset_result", bus.result_o, 32'h0);
        check("reset_busy", 32'(bus.busy_o), 32'd0);
        check("reset_done", 32'(bus.done_o), 32'd0);
        check("reset_stall", 32'(bus.stall_o), 32'd0);
        rst_n = 1'b1;

        runOp(MUL, 32'd7, 32'd6);
        endOp();

        // Back-to-back chain: each op presented in the cycle after the previous DONE
        runOp(MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF);
        runOp(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
        runOp(MULHSU, 32'hFFFF_FFFF, 32'd2);
        runOp(MULH,   MIN_INT,       MIN_INT);
        runOp(MUL,    32'hFFFF_FFF9, 32'd3);
        runOp(DIV,    32'hFFFF_FFF9, 32'd2);
        runOp(REM,    32'hFFFF_FFF9, 32'd2);
        runOp(DIVU,   32'd100,       32'd7);
        runOp(REMU,   32'd100,       32'd7);
        runOp(DIV,    32'd7,         32'hFFFF_FFFE);
        runOp(REM,    32'd7,         32'hFFFF_FFFE);
        runOp(DIVU,   32'hFFFF_FFFF, 32'd1);
        runOp(DIVU,   32'd123,       32'd0);
        runOp(REM,    32'd5,         32'd0);
        runOp(DIV,    MIN_INT,       32'hFFFF_FFFF);
        runOp(REM,    MIN_INT,       32'hFFFF_FFFF);
        runOp(REMU,   32'd9,         32'd4);
        endOp();

        // Flush at BUSY cycle 10: no done, result unchanged
        @(negedge clk);
        bus.start_i  = 1'b1;
        bus.funct3_i = MUL;
        bus.rs1_i    = 32'd123;
        bus.rs2_i    = 32'd456;
        repeat (10) @(negedge clk);
        bus.flush_i = 1'b1;
        #1;
        check("flush_busy_before", 32'(bus.busy_o), 32'd1);
        check("flush_done_forced", 32'(bus.done_o), 32'd0);
        @(negedge clk);
        bus.flush_i = 1'b0;
        bus.start_i = 1'b0;
        #1;
        check("flush_busy_after", 32'(bus.busy_o), 32'd0);
        check("flush_stall_after", 32'(bus.stall_o), 32'd0);
        check("flush_result_kept", bus.result_o, lastResult);
        doneCount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done_o === 1'b1) doneCount++;
        end
        check("flush_no_done", 32'(doneCount), 32'd0);

        // Flush in IDLE blocks acceptance
        bus.start_i  = 1'b1;
        bus.flush_i  = 1'b1;
        bus.funct3_i = DIVU;
        bus.rs1_i    = 32'd10;
        bus.rs2_i    = 32'd3;
        #1;
        check("idle_flush_stall", 32'(bus.stall_o), 32'd0);
        @(negedge clk);
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        #1;
        check("idle_flush_busy", 32'(bus.busy_o), 32'd0);
        check("idle_flush_done", 32'(bus.done_o), 32'd0);

        // Reset mid-BUSY
        @(negedge clk);
        bus.start_i  = 1'b1;
        bus.funct3_i = DIV;
        bus.rs1_i    = 32'd1000;
        bus.rs2_i    = 32'd3;
        repeat (5) @(negedge clk);
        #1;
        check("pre_reset_busy", 32'(bus.busy_o), 32'd1);
        rst_n       = 1'b0;
        bus.start_i = 1'b0;
        #1;
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_done", 32'(bus.done_o), 32'd0);
        check("rst_stall", 32'(bus.stall_o), 32'd0);
        check("rst_result", bus.result_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        runOp(DIVU, 32'd100, 32'd7);
        endOp();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
